// File: rtl/cpu_run_ctrl.sv
//------------------------------------------------------------------------------
// Module  : cpu_run_ctrl
// Purpose : Run/step/halt sequencer issuing a one-cycle CPU clock-enable.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl #(
  parameter int FAST_DIV = 1,
  parameter int SLOW_DIV = 50_000_000,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             resume_btn,
  input  logic             div_sel,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int DIV_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [DIV_W-1:0] C_FAST_LIM = DIV_W'(FAST_DIV - 1);
  localparam logic [DIV_W-1:0] C_SLOW_LIM = DIV_W'(SLOW_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t           r_state, w_next_state;
  logic [DIV_W-1:0] r_div_cnt, w_next_div;
  logic             r_bp_skip, w_next_skip;
  logic             r_step_q, r_resume_q;

  logic             w_step_rise, w_resume_rise, w_tick, w_bp_hit;
  logic [DIV_W-1:0] w_div_lim;

  assign w_step_rise   = step_btn & ~r_step_q;
  assign w_resume_rise = resume_btn & ~r_resume_q;
  assign w_div_lim     = div_sel ? C_SLOW_LIM : C_FAST_LIM;
  // ">=" so a switch to a faster rate mid-count ticks without wrapping around
  assign w_tick        = (r_div_cnt >= w_div_lim);
  assign w_bp_hit      = bp_en && (pc == bp_addr) && !r_bp_skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_div_cnt  <= '0;
      r_bp_skip  <= 1'b0;
      r_step_q   <= 1'b1;
      r_resume_q <= 1'b1;
      cycle_cnt  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_div_cnt  <= w_next_div;
      r_bp_skip  <= w_next_skip;
      r_step_q   <= step_btn;
      r_resume_q <= resume_btn;
      if (cpu_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_div   = r_div_cnt;
    w_next_skip  = r_bp_skip;
    cpu_en       = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_div = '0;
        if (run_sw)           w_next_state = RUN;
        else if (w_step_rise) w_next_state = STEP;
      end
      RUN: begin
        if (w_tick) begin
          w_next_div = '0;
          if (w_bp_hit) begin
            w_next_state = HALT;
          end else begin
            cpu_en      = 1'b1;
            w_next_skip = 1'b0;
            if (halt_req)     w_next_state = HALT;
            else if (!run_sw) w_next_state = IDLE;
          end
        end else if (!run_sw) begin
          w_next_div   = '0;
          w_next_state = IDLE;
        end else begin
          w_next_div = r_div_cnt + DIV_W'(1);
        end
      end
      STEP: begin
        cpu_en       = 1'b1;
        w_next_skip  = 1'b0;
        w_next_state = halt_req ? HALT : IDLE;
      end
      HALT: begin
        // Skip the breakpoint once so resuming executes the trapped instruction
        if (w_resume_rise) begin
          w_next_state = IDLE;
          w_next_skip  = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign state  = r_state;
  assign halted = (r_state == HALT);

endmodule

`default_nettype wire
